sd_wb_master_arbiter: RTL

- Shares the single Wishbone master port of the SD controller between two DMA requesters: requester 0 (RX FIFO filler, memory writes) and requester 1 (TX FIFO filler, memory reads).
- Grants whole Wishbone cycles, not single beats; a grant holds while the granted requester keeps cyc asserted.
- Provides round-robin or fixed-priority arbitration and a programmable ack watchdog, so a stalled slave cannot hang the data path.

---
 rtl/sd_wb_master_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sd_wb_master_arbiter.sv
// Two-requester Wishbone master arbiter for the SD controller DMA path.
// Grants whole bus cycles (round-robin or r0-priority) and aborts stalled slaves via an ack watchdog.
module sd_wb_master_arbiter #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] r0_adr_i,
  input  logic [DAT_W-1:0] r0_dat_i,
  input  logic             r0_we_i,
  input  logic             r0_cyc_i,
  input  logic             r0_stb_i,
  output logic             r0_ack_o,
  output logic             r0_err_o,
  input  logic [ADR_W-1:0] r1_adr_i,
  input  logic [DAT_W-1:0] r1_dat_i,
  input  logic             r1_we_i,
  input  logic             r1_cyc_i,
  input  logic             r1_stb_i,
  output logic             r1_ack_o,
  output logic             r1_err_o,
  output logic [DAT_W-1:0] r_dat_o,
  output logic [ADR_W-1:0] m_wb_adr_o,
  output logic [DAT_W-1:0] m_wb_dat_o,
  output logic             m_wb_we_o,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  input  logic [DAT_W-1:0] m_wb_dat_i,
  input  logic             m_wb_ack_i,
  input  logic             prio_mode_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             to_clr_i,
  output logic [1:0]       grant_o,
  output logic             to_flag_o
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT0, ABORT1} state_t;

  state_t            state_q;
  logic              last_gnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              to_flag_q;
  logic              err0_q;
  logic              err1_q;

  logic req0, req1, gnt0, gnt1, own_cyc, wd_hit;

  assign req0    = r0_cyc_i & r0_stb_i;
  assign req1    = r1_cyc_i & r1_stb_i;
  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign own_cyc = gnt0 ? r0_cyc_i : r1_cyc_i;
  assign wd_hit  = (timeout_i != '0) && (to_cnt_q == timeout_i - TO_W'(1));

  assign m_wb_adr_o = gnt0 ? r0_adr_i : (gnt1 ? r1_adr_i : '0);
  assign m_wb_dat_o = gnt0 ? r0_dat_i : (gnt1 ? r1_dat_i : '0);
  assign m_wb_we_o  = (gnt0 & r0_we_i)  | (gnt1 & r1_we_i);
  assign m_wb_cyc_o = (gnt0 & r0_cyc_i) | (gnt1 & r1_cyc_i);
  assign m_wb_stb_o = (gnt0 & r0_stb_i) | (gnt1 & r1_stb_i);

  assign r0_ack_o  = gnt0 & m_wb_ack_i;
  assign r1_ack_o  = gnt1 & m_wb_ack_i;
  assign r0_err_o  = err0_q;
  assign r1_err_o  = err1_q;
  assign r_dat_o   = m_wb_dat_i;
  assign grant_o   = {gnt1, gnt0};
  assign to_flag_o = to_flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      // A watchdog set later in this block overrides the clear.
      if (to_clr_i) to_flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (req0 && (!req1 || prio_mode_i || last_gnt_q)) state_q <= GNT0;
          else if (req1)                                    state_q <= GNT1;
        end
        GNT0, GNT1: begin
          if (!own_cyc) begin
            state_q    <= IDLE;
            last_gnt_q <= gnt1;
            to_cnt_q   <= '0;
          end else if (m_wb_stb_o && !m_wb_ack_i) begin
            if (wd_hit) begin
              state_q   <= gnt0 ? ABORT0 : ABORT1;
              err0_q    <= gnt0;
              err1_q    <= gnt1;
              to_flag_q <= 1'b1;
              to_cnt_q  <= '0;
            end else if (to_cnt_q != '1) begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end else begin
            to_cnt_q <= '0;
          end
        end
        ABORT0: if (!r0_cyc_i) begin
          state_q    <= IDLE;
          last_gnt_q <= 1'b0;
        end
        ABORT1: if (!r1_cyc_i) begin
          state_q    <= IDLE;
          last_gnt_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
